issue_queue: RTL

//  Parametrised decode/issue buffer between IF and the RS/LSB/ROB back end.

---
 rtl/issue_queue.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// Decode/issue buffer between IF and the RS/LSB/ROB back end; issues one decoded instruction per cycle.
// Optional feature: define ISSUE_BYPASS_EN to let an instruction arriving at an empty queue issue directly from IF.
module issue_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int LS_OP_MIN  = 10,
    parameter int LS_OP_MAX  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  inst_valid,
    input  logic [31:0]           inst_from_if,
    input  logic [31:0]           pc_from_if,
    output logic                  issue_stall,
    input  logic                  rs_full,
    input  logic                  lsb_full,
    input  logic                  rob_full,
    output logic                  rs1_enable,
    output logic [4:0]            rs1_to_reg,
    output logic                  rs2_enable,
    output logic [4:0]            rs2_to_reg,
    output logic                  rs_send_enable,
    output logic                  lsb_send_enable,
    output logic [5:0]            issue_op_type,
    output logic [4:0]            issue_rd,
    output logic [31:0]           issue_imm,
    output logic [31:0]           issue_pc,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [5:0]          LS_MIN    = 6'(LS_OP_MIN);
    localparam logic [5:0]          LS_MAX    = 6'(LS_OP_MAX);
`ifdef ISSUE_BYPASS_EN
    localparam logic                BYPASS    = 1'b1;
`else
    localparam logic                BYPASS    = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        use1;
        logic        use2;
        logic [31:0] imm;
    } dec_t;

    // op_type map: 1 LUI, 2 AUIPC, 3 JAL, 4-9 branches, 10-14 loads, 15-17 stores,
    // 18 JALR, 19-27 OP-IMM, 28-37 OP; anything else decodes to 0 (illegal).
    function automatic dec_t inst_decode(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = inst[14:12];
        f7 = inst[31:25];
        d  = '0;
        case (inst[6:0])
            7'b0110111: begin d.op = 6'd1; d.rd = inst[11:7]; d.imm = {inst[31:12], 12'b0}; end
            7'b0010111: begin d.op = 6'd2; d.rd = inst[11:7]; d.imm = {inst[31:12], 12'b0}; end
            7'b1101111: begin
                d.op  = 6'd3;
                d.rd  = inst[11:7];
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin
                d.op   = (f3 == 3'd0) ? 6'd18 : 6'd0;
                d.rd   = inst[11:7];
                d.use1 = 1'b1;
                d.imm  = {{20{inst[31]}}, inst[31:20]};
            end
            7'b1100011: begin
                case (f3)
                    3'd0: d.op = 6'd4;
                    3'd1: d.op = 6'd5;
                    3'd4: d.op = 6'd6;
                    3'd5: d.op = 6'd7;
                    3'd6: d.op = 6'd8;
                    3'd7: d.op = 6'd9;
                    default: d.op = 6'd0;
                endcase
                d.use1 = 1'b1;
                d.use2 = 1'b1;
                d.imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0000011: begin
                case (f3)
                    3'd0: d.op = 6'd10;
                    3'd1: d.op = 6'd11;
                    3'd2: d.op = 6'd12;
                    3'd4: d.op = 6'd13;
                    3'd5: d.op = 6'd14;
                    default: d.op = 6'd0;
                endcase
                d.rd   = inst[11:7];
                d.use1 = 1'b1;
                d.imm  = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                case (f3)
                    3'd0: d.op = 6'd15;
                    3'd1: d.op = 6'd16;
                    3'd2: d.op = 6'd17;
                    default: d.op = 6'd0;
                endcase
                d.use1 = 1'b1;
                d.use2 = 1'b1;
                d.imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b0010011: begin
                case (f3)
                    3'd0: d.op = 6'd19;
                    3'd2: d.op = 6'd20;
                    3'd3: d.op = 6'd21;
                    3'd4: d.op = 6'd22;
                    3'd6: d.op = 6'd23;
                    3'd7: d.op = 6'd24;
                    3'd1: d.op = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
                    default: d.op = (f7 == 7'b0000000) ? 6'd26 :
                                    (f7 == 7'b0100000) ? 6'd27 : 6'd0;
                endcase
                d.rd   = inst[11:7];
                d.use1 = 1'b1;
                d.imm  = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, inst[24:20]}
                                                    : {{20{inst[31]}}, inst[31:20]};
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0: d.op = 6'd28;
                        3'd1: d.op = 6'd30;
                        3'd2: d.op = 6'd31;
                        3'd3: d.op = 6'd32;
                        3'd4: d.op = 6'd33;
                        3'd5: d.op = 6'd36;
                        3'd6: d.op = 6'd34;
                        default: d.op = 6'd35;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    d.op = (f3 == 3'd0) ? 6'd29 : (f3 == 3'd5) ? 6'd37 : 6'd0;
                end
                d.rd   = inst[11:7];
                d.use1 = 1'b1;
                d.use2 = 1'b1;
            end
            default: d = '0;
        endcase
        if (d.op == 6'd0) d = '0;
        return d;
    endfunction

    logic [31:0]           mem_inst [DEPTH];
    logic [31:0]           mem_pc   [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;

    logic        use_if;
    logic        have;
    logic [31:0] cur_inst;
    logic [31:0] cur_pc;
    dec_t        dec;
    logic        to_lsb;
    logic        tgt_full;
    logic        can_issue;
    logic        pop;
    logic        send;
    logic        bypass_issue;
    logic        push;

    assign issue_stall = (count == FULL_CNT);

    always_comb begin
        use_if       = BYPASS & (count == '0) & inst_valid;
        have         = (count != '0) | use_if;
        cur_inst     = use_if ? inst_from_if : mem_inst[head];
        cur_pc       = use_if ? pc_from_if   : mem_pc[head];
        dec          = inst_decode(cur_inst);
        to_lsb       = (dec.op >= LS_MIN) && (dec.op <= LS_MAX);
        tgt_full     = to_lsb ? lsb_full : rs_full;
        // Illegal entries drain regardless of back-end room.
        can_issue    = rdy & have & ~flush & ((dec.op == 6'd0) | (~rob_full & ~tgt_full));
        pop          = can_issue & (count != '0);
        send         = can_issue & (dec.op != 6'd0);
        bypass_issue = send & use_if;
        push         = rdy & inst_valid & ~issue_stall & ~flush & ~bypass_issue;
        rs1_enable   = have & dec.use1;
        rs2_enable   = have & dec.use2;
        rs1_to_reg   = rs1_enable ? cur_inst[19:15] : 5'd0;
        rs2_to_reg   = rs2_enable ? cur_inst[24:20] : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail] <= inst_from_if;
            mem_pc[tail]   <= pc_from_if;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            rs_send_enable  <= 1'b0;
            lsb_send_enable <= 1'b0;
            issue_op_type   <= '0;
            issue_rd        <= '0;
            issue_imm       <= '0;
            issue_pc        <= '0;
        end else if (rdy) begin
            if (flush) begin
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                rs_send_enable  <= 1'b0;
                lsb_send_enable <= 1'b0;
            end else begin
                if (pop)  head <= head + 1'b1;
                if (push) tail <= tail + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                rs_send_enable  <= send & ~to_lsb;
                lsb_send_enable <= send & to_lsb;
                if (send) begin
                    issue_op_type <= dec.op;
                    issue_rd      <= dec.rd;
                    issue_imm     <= dec.imm;
                    issue_pc      <= cur_pc;
                end
            end
        end
    end

endmodule
